lc3b_mem_arbiter: RTL

Two-port to one-port line arbiter between the instruction cache (IF stage) and data cache (MEM stage) miss paths and the single physical memory port of the LC-3b pipeline. It grants one cache per transaction, round-robin on ties, and latches address and write data for the whole transaction. It returns the memory response only to the granted cache and keeps saturating per-port transaction counters for performance monitoring. The caches stall their pipeline stages, including the MEM/WB register via its `stall` input, until their response arrives.

---
 rtl/lc3b_mem_arbiter.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/lc3b_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : lc3b_mem_arbiter
// Description : Shares the single physical memory port between the I-cache
//               and D-cache miss paths. One cache is granted per transaction
//               (round-robin on simultaneous requests). The address, write
//               data and read/write direction are latched for the whole
//               transaction. The memory response is routed only to the
//               granted cache. Per-port saturating counters record the
//               number of completed transactions.
// Ports       : clk, reset_n              clock, async active-low reset
//               i_read/i_address          I-cache line read request
//               i_resp/i_rdata            I-cache completion and line data
//               d_read/d_write/d_address  D-cache line read/write-back request
//               d_wdata                   D-cache write-back line
//               d_resp/d_rdata            D-cache completion and line data
//               pmem_*                    physical memory port
//               i_count/d_count           completed transactions per port
// Revision    : 1.0  initial release
// ============================================================================
module lc3b_mem_arbiter #(
    parameter int LINE_W = 128,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    // I-cache side
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic              i_resp,
    output logic [LINE_W-1:0] i_rdata,
    // D-cache side
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic              d_resp,
    output logic [LINE_W-1:0] d_rdata,
    // Physical memory side
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp,
    // Performance counters
    output logic [15:0]       i_count,
    output logic [15:0]       d_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_t;

    // Byte-offset bits inside one line; masked off the memory address.
    localparam logic [ADDR_W-1:0] OFFSET_MASK = ADDR_W'((LINE_W / 8) - 1);
    localparam logic [15:0]       COUNT_MAX   = 16'hFFFF;
    localparam logic              GRANT_I     = 1'b0;
    localparam logic              GRANT_D     = 1'b1;

    state_t              state;
    logic                last_grant;
    logic [ADDR_W-1:0]   addr_q;
    logic [LINE_W-1:0]   wdata_q;
    logic                is_write_q;

    logic                i_pend;
    logic                d_pend;
    logic                grant_d;

    assign i_pend  = i_read;
    assign d_pend  = d_read | d_write;
    // D wins when it is alone, or on a tie when I had the previous grant.
    assign grant_d = d_pend & (~i_pend | (last_grant == GRANT_I));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            last_grant <= GRANT_I;
            addr_q     <= '0;
            wdata_q    <= '0;
            is_write_q <= 1'b0;
            i_count    <= '0;
            d_count    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        state      <= SERVE_D;
                        last_grant <= GRANT_D;
                        addr_q     <= d_address;
                        wdata_q    <= d_wdata;
                        // A simultaneous read+write becomes a write; the read
                        // must be requested again afterwards.
                        is_write_q <= d_write;
                    end else if (i_pend) begin
                        state      <= SERVE_I;
                        last_grant <= GRANT_I;
                        addr_q     <= i_address;
                        is_write_q <= 1'b0;
                    end
                end
                SERVE_I: begin
                    if (pmem_resp) begin
                        state <= IDLE;
                        if (i_count != COUNT_MAX) begin
                            i_count <= i_count + 16'd1;
                        end
                    end
                end
                SERVE_D: begin
                    if (pmem_resp) begin
                        state <= IDLE;
                        if (d_count != COUNT_MAX) begin
                            d_count <= d_count + 16'd1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Memory strobes depend only on registered state, so an asynchronous
    // reset removes them immediately.
    assign pmem_read    = (state == SERVE_I) | ((state == SERVE_D) & ~is_write_q);
    assign pmem_write   = (state == SERVE_D) & is_write_q;
    assign pmem_address = addr_q & ~OFFSET_MASK;
    assign pmem_wdata   = wdata_q;

    assign i_resp  = (state == SERVE_I) & pmem_resp;
    assign d_resp  = (state == SERVE_D) & pmem_resp;
    assign i_rdata = pmem_rdata;
    assign d_rdata = pmem_rdata;

endmodule
`default_nettype wire
